div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider that executes DIV/DIVU after the main decoder has flagged them.
- The decoder raises hilo_write_en, and unsign_extend selects DIVU.
- Sits in the EX stage. It stalls the pipeline while busy and returns {HI=remainder, LO=quotient} for the HILO register write.

Parameters:
- WIDTH, 32, operand width in bits. The result is 2*WIDTH bits.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request a division. Sampled only in IDLE.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU. Sampled with start.
- annul  input  1  flush (exception or branch squash). Abandons the current operation.
- opdata_a  input  WIDTH  dividend (rs). Sampled with start.
- opdata_b  input  WIDTH  divisor (rt). Sampled with start.
- result  output  2*WIDTH  {remainder, quotient}, i.e. {HI, LO}. Valid while ready=1.
- ready  output  1  result valid. One-cycle pulse.
- stall  output  1  hold IF/ID/EX. Combinational.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; result=0, ready=0; counter and internal registers cleared.
  - Reset mid-operation abandons the operation with no ready pulse.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - start=1 and annul=0 latches the operands and signed_div.
  - opdata_b==0 → DIVZERO; otherwise → BUSY with counter=0.
  - In signed mode the operands are converted to absolute values (unsigned WIDTH-bit magnitudes) at latch time. The sign of a and the sign of a XOR sign of b are stored.
- BUSY, one iteration per cycle:
  - Shift the remainder:dividend pair left by 1; trial-subtract the divisor from the upper WIDTH+1 bits.
  - If there is no borrow, keep the difference and shift 1 into the quotient; otherwise shift 0.
  - The counter increments each cycle. After the iteration with counter==WIDTH-1 → DONE.
  - BUSY therefore lasts exactly WIDTH cycles.
- DONE, held one cycle:
  - ready=1. result = {rem, quo} after sign fix-up, then → IDLE.
  - Sign fix-up in signed mode only: quotient negated if the operand signs differ; remainder negated if the dividend was negative (remainder sign follows the dividend).
- DIVZERO: one cycle, then DONE with result = {opdata_a latched, all-ones}. This is deterministic; MIPS leaves the value undefined.
- Latency: start accepted at edge 0 → ready high in cycle WIDTH+1 (33 for 32-bit). Divide by zero → ready in cycle 2.
- stall is 1 when:
  - (state==IDLE and start and not annul), or
  - state is BUSY or DIVZERO.
  - stall is 0 in DONE, so the pipeline advances on the same cycle it consumes result.
- result is registered and holds its value after DONE until the next DONE or reset. ready is valid for exactly one cycle.
- annul=1 in any state → IDLE at the next edge, no ready pulse, stall=0 that cycle. annul has priority over start and over the DONE transition.
- start while not in IDLE is ignored. Operand changes after acceptance have no effect.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. Magnitude 2^31 fits unsigned WIDTH, and negation wraps.
- Arithmetic is modulo 2^WIDTH. The trial subtraction uses WIDTH+1 bits to detect borrow.

Test Plan:
- DIVU basic: unsigned 100 / 7, start pulse → stall high for 33 cycles; ready in cycle 33; result = {32'h2, 32'hE}.
- DIVU large dividend: unsigned 0xFFFFFFF9 / 2 → result = {32'h1, 32'h7FFFFFFC}. Confirms no signed interpretation.
- DIV signed: -7 / 2 → {32'hFFFFFFFF, 32'hFFFFFFFD}. 7 / -2 → {32'h1, 32'hFFFFFFFD}. 0x80000000 / 0xFFFFFFFF → {0, 32'h80000000}.
- Divide by zero: 5 / 0 → ready in cycle 2; result = {32'h5, 32'hFFFFFFFF}; stall drops in the DONE cycle.
- Annul and ignored start: annul at BUSY cycle 10 → IDLE next edge, no ready, result unchanged. A new start is then accepted normally. A start asserted during BUSY is ignored: exactly one ready pulse, operands from the first start.
- Reset mid-op: rst at BUSY cycle 20 → next cycle result=0, ready=0, stall=0. A subsequent 9 / 3 gives {0, 3} after 33 cycles.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {HI=remainder, LO=quotient}; stalls the pipeline while busy.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata_a,
  input  logic [WIDTH-1:0]   opdata_b,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DIVZERO,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] divisor;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic             borrow;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;
  logic             take_start;
  logic             last;

  assign take_start = (state == IDLE) && start && !annul;
  assign last       = (counter == CW'(WIDTH - 1));

  // Operand magnitudes; 2^(WIDTH-1) wraps onto itself and is a valid magnitude.
  always_comb begin
    a_mag = opdata_a;
    b_mag = opdata_b;
    if (signed_div && opdata_a[WIDTH-1]) begin
      a_mag = -opdata_a;
    end
    if (signed_div && opdata_b[WIDTH-1]) begin
      b_mag = -opdata_b;
    end
  end

  // One restoring step: WIDTH+1-bit trial compare decides the quotient bit.
  // The partial remainder stays below the divisor, so a successful
  // subtraction always fits back into WIDTH bits.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    borrow  = shifted < {1'b0, divisor};
    diff    = shifted[WIDTH-1:0] - divisor;
    rem_n   = borrow ? shifted[WIDTH-1:0] : diff;
    quo_n   = {dvd[WIDTH-2:0], ~borrow};
    quo_fix = neg_q ? -quo_n : quo_n;
    rem_fix = neg_r ? -rem_n : rem_n;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and handshake outputs; annul overrides every transition.
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_start) begin
          state_n = (opdata_b == '0) ? DIVZERO : BUSY;
          stall   = 1'b1;
        end
      end
      DIVZERO: begin
        state_n = DONE;
        stall   = 1'b1;
      end
      BUSY: begin
        stall = 1'b1;
        if (last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        ready   = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (annul) begin
      state_n = IDLE;
      ready   = 1'b0;
      stall   = 1'b0;
    end
  end

  // Operand latch, iteration datapath and result register.
  // The result is written on the edge that enters DONE so it is
  // valid for the whole ready cycle and held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      rem     <= '0;
      dvd     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take_start) begin
            counter <= '0;
            rem     <= '0;
            divisor <= b_mag;
            dvd     <= (opdata_b == '0) ? opdata_a : a_mag;
            neg_q   <= signed_div & (opdata_a[WIDTH-1] ^ opdata_b[WIDTH-1]);
            neg_r   <= signed_div & opdata_a[WIDTH-1];
          end
        end
        BUSY: begin
          if (!annul) begin
            rem     <= rem_n;
            dvd     <= quo_n;
            counter <= counter + CW'(1);
            if (last) begin
              result <= {rem_fix, quo_fix};
            end
          end
        end
        DIVZERO: begin
          if (!annul) begin
            result <= {dvd, {WIDTH{1'b1}}};
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
